// File: rtl/wts_tone_generator_5ch.sv
// Five-channel wavetable tone generator: per-channel step counters and sample pointers
// with a combinational output mux. Optional macro WTS_WAVE_LENGTH_EN enables wave-length decoding.
module wts_tone_generator_5ch (
    input  logic        clk,
    input  logic        nreset,
    input  logic [2:0]  active,
    input  logic        address_reset,
    input  logic [1:0]  reg_wave_length_a,
    input  logic [1:0]  reg_wave_length_b,
    input  logic [1:0]  reg_wave_length_c,
    input  logic [1:0]  reg_wave_length_d,
    input  logic [1:0]  reg_wave_length_e,
    input  logic [11:0] reg_frequency_count_a,
    input  logic [11:0] reg_frequency_count_b,
    input  logic [11:0] reg_frequency_count_c,
    input  logic [11:0] reg_frequency_count_d,
    input  logic [11:0] reg_frequency_count_e,
    output logic [6:0]  wave_address,
    output logic        half_timing
);

    localparam int unsigned NUM_CH = 5;
    localparam int unsigned CNT_W  = 12;
    localparam int unsigned PTR_W  = 7;

    logic [NUM_CH-1:0][CNT_W-1:0] freq;
    logic [NUM_CH-1:0][1:0]       len_code;
    logic [NUM_CH-1:0][PTR_W-1:0] mask;
    logic [NUM_CH-1:0][PTR_W-1:0] half_pt;
    logic [NUM_CH-1:0][PTR_W-1:0] ptr_inc;

    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0][PTR_W-1:0] ptr_q, ptr_d;
    logic [NUM_CH-1:0]            half_q, half_d;

    assign freq = {reg_frequency_count_e, reg_frequency_count_d, reg_frequency_count_c,
                   reg_frequency_count_b, reg_frequency_count_a};
    assign len_code = {reg_wave_length_e, reg_wave_length_d, reg_wave_length_c,
                       reg_wave_length_b, reg_wave_length_a};

`ifdef WTS_WAVE_LENGTH_EN
    function automatic logic [PTR_W-1:0] mask_of(input logic [1:0] code);
        case (code)
            2'b00:   mask_of = 7'd31;
            2'b01:   mask_of = 7'd63;
            2'b10:   mask_of = 7'd127;
            default: mask_of = 7'd15;
        endcase
    endfunction

    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mask[i] = mask_of(len_code[i]);
        end
    end
`else
    // Fixed 32-sample tables; the length registers are deliberately not observed.
    logic unused_wave_length;
    assign unused_wave_length = ^len_code;

    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mask[i] = 7'd31;
        end
    end
`endif

    // Midpoint L/2 and the masked next pointer per channel.
    always_comb begin
        half_pt = '0;
        ptr_inc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            half_pt[i] = PTR_W'((mask[i] >> 1) + 7'd1);
            ptr_inc[i] = PTR_W'(ptr_q[i] + 7'd1) & mask[i];
        end
    end

    // Restart, step or count down.
    always_comb begin
        cnt_d  = cnt_q;
        ptr_d  = ptr_q;
        half_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (address_reset) begin
                cnt_d[i] = freq[i];
                ptr_d[i] = '0;
            end else if (cnt_q[i] == '0) begin
                cnt_d[i]  = freq[i];
                ptr_d[i]  = ptr_inc[i];
                half_d[i] = (ptr_inc[i] == half_pt[i]);
            end else begin
                cnt_d[i] = CNT_W'(cnt_q[i] - 12'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            cnt_q  <= freq;
            ptr_q  <= '0;
            half_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ptr_q  <= ptr_d;
            half_q <= half_d;
        end
    end

    // Output select; channels 5..7 read as idle.
    always_comb begin
        wave_address = '0;
        half_timing  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (active == 3'(i)) begin
                wave_address = ptr_q[i] & mask[i];
                half_timing  = half_q[i];
            end
        end
    end

endmodule

// File: tb/tb_wts_tone_generator_5ch.sv
// Directed bench for wts_tone_generator_5ch: vector table of per-channel sequences
// plus hand-written reset, multi-channel and frequency-change cases.
module tb_wts_tone_generator_5ch;

    logic        clk = 1'b0;
    logic        nreset;
    logic [2:0]  active;
    logic        address_reset;
    logic [1:0]  wl_a, wl_b, wl_c, wl_d, wl_e;
    logic [11:0] fq_a, fq_b, fq_c, fq_d, fq_e;
    logic [6:0]  wave_address;
    logic        half_timing;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 clk = ~clk;

    wts_tone_generator_5ch dut (
        .clk                   (clk),
        .nreset                (nreset),
        .active                (active),
        .address_reset         (address_reset),
        .reg_wave_length_a     (wl_a),
        .reg_wave_length_b     (wl_b),
        .reg_wave_length_c     (wl_c),
        .reg_wave_length_d     (wl_d),
        .reg_wave_length_e     (wl_e),
        .reg_frequency_count_a (fq_a),
        .reg_frequency_count_b (fq_b),
        .reg_frequency_count_c (fq_c),
        .reg_frequency_count_d (fq_d),
        .reg_frequency_count_e (fq_e),
        .wave_address          (wave_address),
        .half_timing           (half_timing)
    );

`ifdef WTS_WAVE_LENGTH_EN
    localparam int LEN01 = 64;
    localparam int LEN10 = 128;
    localparam int LEN11 = 16;
`else
    localparam int LEN01 = 32;
    localparam int LEN10 = 32;
    localparam int LEN11 = 32;
`endif

    typedef struct {
        int         freq;
        logic [1:0] code;
        int         exp_len;
        int         ncyc;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [6:0] ea, input logic eh);
        n_tests++;
        if (wave_address !== ea || half_timing !== eh) begin
            n_fail++;
            $display("FAIL %s: got addr=%0d half=%0b, want addr=%0d half=%0b",
                     name, wave_address, half_timing, ea, eh);
        end
    endtask

    task automatic restart();
        address_reset = 1'b1;
        step();
        address_reset = 1'b0;
    endtask

    // Checks n cycles starting from the cycle right after a restart edge (j = 0).
    task automatic run_seq(input int f, input int len, input int n, input string tag);
        int a;
        logic h;
        for (int j = 0; j < n; j++) begin
            if (j > 0) step();
            a = (j / (f + 1)) % len;
            h = (j > 0) && (j % (f + 1) == 0) && (a == len / 2);
            chk($sformatf("%s j=%0d", tag, j), 7'(a), h);
        end
    endtask

    initial begin
        vecs[0] = '{0, 2'b00, 32,    70};
        vecs[1] = '{1, 2'b00, 32,    140};
        vecs[2] = '{2, 2'b00, 32,    200};
        vecs[3] = '{0, 2'b01, LEN01, 2 * LEN01 + 3};
        vecs[4] = '{0, 2'b10, LEN10, 2 * LEN10 + 3};
        vecs[5] = '{0, 2'b11, LEN11, 2 * LEN11 + 3};

        nreset = 1'b1;
        address_reset = 1'b0;
        active = 3'd0;
        {wl_a, wl_b, wl_c, wl_d, wl_e} = '0;
        {fq_a, fq_b, fq_c, fq_d, fq_e} = {5{12'd4095}};
        step();
        step();
        nreset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            active = 3'(c);
            #1;
            chk($sformatf("reset ch%0d", c), 7'd0, 1'b0);
        end

        // Channel A sequences from the vector table.
        active = 3'd0;
        foreach (vecs[v]) begin
            fq_a = 12'(vecs[v].freq);
            wl_a = vecs[v].code;
            restart();
            run_seq(vecs[v].freq, vecs[v].exp_len, vecs[v].ncyc, $sformatf("vec%0d", v));
        end

        // Five independent channels, outputs swept through every active code.
        wl_a = 2'b00;
        fq_a = 12'd0; fq_b = 12'd1; fq_c = 12'd2; fq_d = 12'd3; fq_e = 12'd4;
        restart();
        for (int j = 0; j < 70; j++) begin
            if (j > 0) step();
            for (int c = 0; c < 8; c++) begin
                int a;
                logic h;
                active = 3'(c);
                #1;
                if (c < 5) begin
                    a = (j / (c + 1)) % 32;
                    h = (j > 0) && (j % (c + 1) == 0) && (a == 16);
                end else begin
                    a = 0;
                    h = 1'b0;
                end
                chk($sformatf("multi j=%0d act=%0d", j, c), 7'(a), h);
            end
        end

        // Reset asserted mid-run at address 20 with freq 3.
        active = 3'd0;
        fq_a = 12'd3;
        restart();
        run_seq(3, 32, 82, "pre_rst");
        nreset = 1'b1;
        step();
        nreset = 1'b0;
        chk("rst_mid", 7'd0, 1'b0);
        run_seq(3, 32, 12, "post_rst");

        // Frequency change 0 -> 9 while running: current step finishes at old rate.
        fq_a = 12'd0;
        restart();
        run_seq(0, 32, 6, "pre_fchg");
        fq_a = 12'd9;
        for (int k = 1; k <= 21; k++) begin
            step();
            chk($sformatf("fchg k=%0d", k), (k <= 10) ? 7'd6 : (k <= 20) ? 7'd7 : 7'd8, 1'b0);
        end

        // Restart held several cycles keeps pointer at 0.
        fq_a = 12'd0;
        address_reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("hold_rst k=%0d", k), 7'd0, 1'b0);
        end
        address_reset = 1'b0;
        run_seq(0, 32, 4, "after_hold");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
